// File: rtl/core_wb_arbiter.sv
// Register-file writeback arbiter: MEM beats EX by default, EX wins after MAX_WAIT refusals.
// Optional macro CORE_WB_STAT_EN adds a saturating conflict-cycle counter port.
module core_wb_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_in,
    output logic              ex_ready_out,
    input  logic [ADDR_W-1:0] ex_addr_in,
    input  logic [DATA_W-1:0] ex_data_in,
    input  logic              mem_valid_in,
    output logic              mem_ready_out,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              we_out,
    output logic [ADDR_W-1:0] write_addr_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic              conflict_out
`ifdef CORE_WB_STAT_EN
    ,
    output logic [15:0]       stat_conflicts_out
`endif
);

    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_nxt;
    logic              w_both;
    logic              w_same_addr;
    logic              w_ex_pri;
    logic              w_ex_grant;
    logic              w_mem_grant;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_both      = ex_valid_in && mem_valid_in;
    assign w_same_addr = (ex_addr_in == mem_addr_in);
    assign w_ex_pri    = (r_wait_cnt == 4'(MAX_WAIT));

    // Same-address collisions always go to MEM so the older write lands first.
    always_comb begin
        w_ex_grant  = 1'b0;
        w_mem_grant = 1'b0;
        if (!rst) begin
            if (w_both) begin
                if (w_same_addr || !w_ex_pri) begin
                    w_mem_grant = 1'b1;
                end else begin
                    w_ex_grant = 1'b1;
                end
            end else begin
                w_ex_grant  = ex_valid_in;
                w_mem_grant = mem_valid_in;
            end
        end
    end

    assign ex_ready_out  = w_ex_grant;
    assign mem_ready_out = w_mem_grant;
    assign w_xfer        = w_ex_grant || w_mem_grant;
    assign w_sel_addr    = w_ex_grant ? ex_addr_in : mem_addr_in;
    assign w_sel_data    = w_ex_grant ? ex_data_in : mem_data_in;

    always_comb begin
        w_wait_nxt = 4'd0;
        if (ex_valid_in && !w_ex_grant) begin
            w_wait_nxt = w_ex_pri ? r_wait_cnt : r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt     <= 4'd0;
            we_out         <= 1'b0;
            write_addr_out <= '0;
            write_data_out <= '0;
            conflict_out   <= 1'b0;
        end else begin
            r_wait_cnt   <= w_wait_nxt;
            conflict_out <= w_both;
            // Writes to x0 are accepted but never reach the register file.
            we_out       <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                write_addr_out <= w_sel_addr;
                write_data_out <= w_sel_data;
            end
        end
    end

`ifdef CORE_WB_STAT_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt <= 16'd0;
        end else if (w_both && (r_stat_cnt != 16'hFFFF)) begin
            r_stat_cnt <= r_stat_cnt + 16'd1;
        end
    end

    assign stat_conflicts_out = r_stat_cnt;
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: a cycle model pushes expected writes, popped after each edge.
// Covers CORE_WB_STAT_EN when that macro is defined.
module tb_core_wb_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        conf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_in, mem_valid_in;
    logic        ex_ready_out, mem_ready_out;
    logic [4:0]  ex_addr_in, mem_addr_in;
    logic [31:0] ex_data_in, mem_data_in;
    logic        we_out, conflict_out;
    logic [4:0]  write_addr_out;
    logic [31:0] write_data_out;
`ifdef CORE_WB_STAT_EN
    logic [15:0] stat_conflicts_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    exp_t        sb[$];
    int          m_wait;
    int          m_stat;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    core_wb_arbiter #(
        .ADDR_W  (5),
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_in   (ex_valid_in),
        .ex_ready_out  (ex_ready_out),
        .ex_addr_in    (ex_addr_in),
        .ex_data_in    (ex_data_in),
        .mem_valid_in  (mem_valid_in),
        .mem_ready_out (mem_ready_out),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .we_out        (we_out),
        .write_addr_out(write_addr_out),
        .write_data_out(write_data_out),
        .conflict_out  (conflict_out)
`ifdef CORE_WB_STAT_EN
        ,
        .stat_conflicts_out(stat_conflicts_out)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check readies, push expectation, pop and compare after posedge.
    task automatic drive_cycle(input logic r, input logic exv, input logic [4:0] exa,
                               input logic [31:0] exd, input logic memv, input logic [4:0] mema,
                               input logic [31:0] memd, output logic ex_acc,
                               output logic mem_acc);
        exp_t       e;
        exp_t       got;
        logic       eg, mg;
        logic [4:0] sa;
        @(negedge clk);
        rst          = r;
        ex_valid_in  = exv;
        ex_addr_in   = exa;
        ex_data_in   = exd;
        mem_valid_in = memv;
        mem_addr_in  = mema;
        mem_data_in  = memd;
        #1;
        eg = 1'b0;
        mg = 1'b0;
        if (!r) begin
            if (exv && memv) begin
                if (exa == mema || m_wait != MAX_WAIT) mg = 1'b1;
                else eg = 1'b1;
            end else begin
                eg = exv;
                mg = memv;
            end
        end
        check_val("ex_ready", ex_ready_out, eg);
        check_val("mem_ready", mem_ready_out, mg);
        if (r) begin
            m_wait = 0;
            m_stat = 0;
            m_addr = '0;
            m_data = '0;
            e.we   = 1'b0;
            e.conf = 1'b0;
        end else begin
            sa     = eg ? exa : mema;
            e.we   = (eg || mg) && (sa != 5'd0);
            e.conf = exv && memv;
            if (eg || mg) begin
                m_addr = sa;
                m_data = eg ? exd : memd;
            end
            if (exv && !eg) m_wait = (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else m_wait = 0;
            if (exv && memv && m_stat < 65535) m_stat++;
        end
        e.addr = m_addr;
        e.data = m_data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("we_out", we_out, got.we);
        check_val("write_addr", write_addr_out, got.addr);
        check_val("write_data", write_data_out, got.data);
        check_val("conflict", conflict_out, got.conf);
        check_val("wait_cnt", dut.r_wait_cnt, m_wait);
`ifdef CORE_WB_STAT_EN
        check_val("stat", stat_conflicts_out, m_stat);
`endif
        ex_acc  = eg;
        mem_acc = mg;
    endtask

    initial begin
        logic        ea, ma;
        logic        pev, pmv;
        logic [4:0]  pea, pma;
        logic [31:0] ped, pmd;
        m_wait = 0;
        m_stat = 0;
        m_addr = '0;
        m_data = '0;

        // Reset with requests present: no grants, all outputs zero.
        drive_cycle(1, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, ea, ma);
        drive_cycle(1, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, ea, ma);

        // Lone EX request.
        drive_cycle(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, ea, ma);
        check_val("t1_ex_acc", ea, 1'b1);
        check_val("t1_addr", write_addr_out, 32'd5);
        check_val("t1_data", write_data_out, 32'h1234);
        drive_cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ea, ma);

        // Conflict: MEM first, then EX.
        drive_cycle(0, 1, 5'd3, 32'hE3, 1, 5'd4, 32'hA4, ea, ma);
        check_val("t2_mem_first", ma, 1'b1);
        check_val("t2_addr1", write_addr_out, 32'd4);
        check_val("t2_conf", conflict_out, 1'b1);
        drive_cycle(0, 1, 5'd3, 32'hE3, 0, 5'd0, 32'h0, ea, ma);
        check_val("t2_ex_next", ea, 1'b1);
        check_val("t2_addr2", write_addr_out, 32'd3);
        drive_cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ea, ma);

        // Starvation: EX refused four times, granted on the fifth.
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 5'd2, 32'hA0, 1, 5'd1, 32'(i), ea, ma);
            check_val("starve_ex", ea, (i == 4));
        end
        check_val("starve_wait_clr", dut.r_wait_cnt, 32'd0);
        drive_cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ea, ma);

        // Same address at full wait: MEM still wins.
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, 5'd7, 32'hB7, 1, 5'd8, 32'(i), ea, ma);
        check_val("same_wait_full", dut.r_wait_cnt, 32'(MAX_WAIT));
        drive_cycle(0, 1, 5'd7, 32'hB7, 1, 5'd7, 32'hC7, ea, ma);
        check_val("same_mem_wins", ma, 1'b1);
        check_val("same_mem_data", write_data_out, 32'hC7);
        drive_cycle(0, 1, 5'd7, 32'hB7, 0, 5'd0, 32'h0, ea, ma);
        check_val("same_ex_next", ea, 1'b1);
        check_val("same_ex_data", write_data_out, 32'hB7);

        // Write to x0 is accepted but not enabled.
        drive_cycle(0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0, ea, ma);
        check_val("x0_acc", ea, 1'b1);
        check_val("x0_we", we_out, 1'b0);

        // Reset during active traffic.
        drive_cycle(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'h1A, ea, ma);
        drive_cycle(0, 1, 5'd9, 32'h99, 1, 5'd11, 32'h1B, ea, ma);
        drive_cycle(1, 1, 5'd9, 32'h99, 1, 5'd12, 32'h1C, ea, ma);
        check_val("rst_we", we_out, 1'b0);
        check_val("rst_wait", dut.r_wait_cnt, 32'd0);

        // Random traffic honouring hold-until-accepted.
        pev = 1'b0;
        pmv = 1'b0;
        pea = '0;
        pma = '0;
        ped = '0;
        pmd = '0;
        for (int i = 0; i < 80; i++) begin
            if (!pev && $urandom_range(0, 2) != 0) begin
                pev = 1'b1;
                pea = 5'($urandom_range(0, 7));
                ped = $urandom;
            end
            if (!pmv && $urandom_range(0, 2) != 0) begin
                pmv = 1'b1;
                pma = 5'($urandom_range(0, 7));
                pmd = $urandom;
            end
            drive_cycle(0, pev, pea, ped, pmv, pma, pmd, ea, ma);
            if (ea) pev = 1'b0;
            if (ma) pmv = 1'b0;
        end

`ifdef CORE_WB_STAT_EN
        drive_cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ea, ma);
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, ea, ma);
        drive_cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ea, ma);
        check_val("stat3", stat_conflicts_out, 32'd3);
        @(negedge clk);
        ex_valid_in  = 1'b1;
        mem_valid_in = 1'b1;
        for (int i = 0; i < 70000; i++) @(negedge clk);
        check_val("stat_sat", stat_conflicts_out, 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
